// File: rtl/dma_pkg.sv
// Shared types for the 8237A-style transfer-cycle sequencer: state encoding,
// channel mode/type encodings and the command-strobe bundle.
package dma_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5,
        SW = 3'd6
    } dma_state_t;

    typedef enum logic [1:0] {
        MODE_DEMAND  = 2'b00,
        MODE_SINGLE  = 2'b01,
        MODE_BLOCK   = 2'b10,
        MODE_CASCADE = 2'b11
    } xfer_mode_t;

    typedef enum logic [1:0] {
        TYPE_VERIFY = 2'b00,
        TYPE_WRITE  = 2'b01,
        TYPE_READ   = 2'b10,
        TYPE_RSVD   = 2'b11
    } xfer_type_t;

    typedef struct packed {
        logic memr_n;
        logic memw_n;
        logic ior_n;
        logic iow_n;
    } cmd_strobes_t;

    localparam cmd_strobes_t CMD_IDLE = '{memr_n: 1'b1, memw_n: 1'b1, ior_n: 1'b1, iow_n: 1'b1};

endpackage

// File: rtl/dma_strobe_decode.sv
// Combinational command-strobe map: the read-side strobe falls in S2, the
// write-side strobe joins it in S3 and both are held through SW.
module dma_strobe_decode
    import dma_pkg::*;
(
    input  dma_state_t   state,
    input  xfer_type_t   xtype,
    output cmd_strobes_t cmd
);

    logic rd_phase;
    logic wr_phase;

    assign rd_phase = (state == S2) || (state == S3) || (state == SW);
    assign wr_phase = (state == S3) || (state == SW);

    always_comb begin
        cmd = CMD_IDLE;
        case (xtype)
            TYPE_WRITE: begin
                cmd.ior_n  = ~rd_phase;
                cmd.memw_n = ~wr_phase;
            end
            TYPE_READ: begin
                cmd.memr_n = ~rd_phase;
                cmd.iow_n  = ~wr_phase;
            end
            default: cmd = CMD_IDLE;
        endcase
    end

endmodule

// File: rtl/dma_timing_control.sv
// Transfer-cycle sequencer: HRQ/HLDA handshake, SI..S4/SW stepping, command
// strobes, DACK enables and per-transfer update pulse. All outputs registered.
module dma_timing_control
    import dma_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              validDREQ,
    input  logic [NUM_CH-1:0] grant,
    input  logic [NUM_CH-1:0] dreqLive,
    input  logic [1:0]        xferMode,
    input  logic [1:0]        xferType,
    input  logic              ctrlDisable,
    input  logic              HLDA,
    input  logic              READY,
    input  logic              EOP_in_n,
    input  logic              tc,
    output logic              HRQ,
    output logic              AEN,
    output logic              ADSTB,
    output logic              MEMR_n,
    output logic              MEMW_n,
    output logic              IOR_n,
    output logic              IOW_n,
    output logic              EOP_out_n,
    output logic [NUM_CH-1:0] dackEn,
    output logic              updateStrobe,
    output logic [CH_W-1:0]   activeCh,
    output logic              busy
);

    dma_state_t        state, nstate;
    logic [NUM_CH-1:0] ch_q, ch_n;
    xfer_mode_t        mode_q, mode_n;
    xfer_type_t        type_q, type_n;
    logic              pend_q, pend_n;
    logic              term_q;
    logic              live_act;
    logic              casc_q, casc_n;
    logic              dack_n;
    logic              xfer_n;
    logic              term_n;
    cmd_strobes_t      cmd_n;

    assign live_act = |(dreqLive & ch_q);
    assign casc_q   = (mode_q == MODE_CASCADE);
    assign casc_n   = (mode_n == MODE_CASCADE);

    always_comb begin
        nstate = state;
        ch_n   = ch_q;
        mode_n = mode_q;
        type_n = type_q;
        pend_n = pend_q;
        case (state)
            SI: begin
                pend_n = 1'b0;
                if (validDREQ && !ctrlDisable) begin
                    nstate = S0;
                    ch_n   = grant;
                    mode_n = xfer_mode_t'(xferMode);
                    type_n = xfer_type_t'(xferType);
                end
            end
            S0: begin
                if (!validDREQ || !EOP_in_n) nstate = SI;
                else if (HLDA)               nstate = S1;
            end
            S1: begin
                // Cascade parks in S1 until the slave drops its request.
                if (!HLDA)                   nstate = SI;
                else if (casc_q)             nstate = live_act ? S1 : SI;
                else                         nstate = S2;
            end
            S2: nstate = HLDA ? S3 : SI;
            S3, SW: begin
                if (!HLDA)                   nstate = SI;
                else                         nstate = READY ? S4 : SW;
            end
            S4: begin
                case (mode_q)
                    MODE_BLOCK:  nstate = term_q ? SI : S1;
                    MODE_DEMAND: nstate = (live_act && !term_q) ? S1 : SI;
                    default:     nstate = SI;
                endcase
            end
            default: nstate = SI;
        endcase

        if (!casc_q && !EOP_in_n &&
            (state == S1 || state == S2 || state == S3 || state == SW))
            pend_n = 1'b1;
    end

    // Termination is fixed on entry to S4 so EOP_out_n and the S4 exit agree.
    assign term_n = tc | pend_n;
    assign dack_n = (nstate == S1) || (nstate == S2) || (nstate == S3) ||
                    (nstate == S4) || (nstate == SW);
    assign xfer_n = dack_n && !casc_n;

    dma_strobe_decode u_decode (
        .state (nstate),
        .xtype (type_n),
        .cmd   (cmd_n)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= SI;
            ch_q         <= '0;
            mode_q       <= MODE_DEMAND;
            type_q       <= TYPE_VERIFY;
            pend_q       <= 1'b0;
            term_q       <= 1'b0;
            HRQ          <= 1'b0;
            busy         <= 1'b0;
            AEN          <= 1'b0;
            ADSTB        <= 1'b0;
            dackEn       <= '0;
            MEMR_n       <= 1'b1;
            MEMW_n       <= 1'b1;
            IOR_n        <= 1'b1;
            IOW_n        <= 1'b1;
            updateStrobe <= 1'b0;
            EOP_out_n    <= 1'b1;
        end else begin
            state        <= nstate;
            ch_q         <= ch_n;
            mode_q       <= mode_n;
            type_q       <= type_n;
            pend_q       <= pend_n;
            term_q       <= term_n;
            HRQ          <= (nstate != SI);
            busy         <= (nstate != SI);
            AEN          <= xfer_n;
            ADSTB        <= (nstate == S1) && !casc_n;
            dackEn       <= dack_n ? ch_n : '0;
            MEMR_n       <= casc_n ? 1'b1 : cmd_n.memr_n;
            MEMW_n       <= casc_n ? 1'b1 : cmd_n.memw_n;
            IOR_n        <= casc_n ? 1'b1 : cmd_n.ior_n;
            IOW_n        <= casc_n ? 1'b1 : cmd_n.iow_n;
            updateStrobe <= (nstate == S4);
            EOP_out_n    <= !((nstate == S4) && term_n);
        end
    end

    always_comb begin
        activeCh = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (ch_q[i]) activeCh = activeCh | CH_W'(i);
    end

endmodule

// File: tb/tb_dma_timing_control.sv
// Randomized bench: per-cycle biased random inputs, outputs compared each cycle
// against a transfer-level model (bus phase, cycle index within transfer).
module tb_dma_timing_control;
    import dma_pkg::*;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              validDREQ = 1'b0;
    logic [NUM_CH-1:0] grant = 4'b0001;
    logic [NUM_CH-1:0] dreqLive = '0;
    logic [1:0]        xferMode = 2'b00;
    logic [1:0]        xferType = 2'b00;
    logic              ctrlDisable = 1'b0;
    logic              HLDA = 1'b0;
    logic              READY = 1'b1;
    logic              EOP_in_n = 1'b1;
    logic              tc = 1'b0;
    logic              HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n, EOP_out_n;
    logic [NUM_CH-1:0] dackEn;
    logic              updateStrobe, busy;
    logic [CH_W-1:0]   activeCh;

    dma_timing_control dut (
        .CLK(CLK), .RESET(RESET), .validDREQ(validDREQ), .grant(grant),
        .dreqLive(dreqLive), .xferMode(xferMode), .xferType(xferType),
        .ctrlDisable(ctrlDisable), .HLDA(HLDA), .READY(READY),
        .EOP_in_n(EOP_in_n), .tc(tc), .HRQ(HRQ), .AEN(AEN), .ADSTB(ADSTB),
        .MEMR_n(MEMR_n), .MEMW_n(MEMW_n), .IOR_n(IOR_n), .IOW_n(IOW_n),
        .EOP_out_n(EOP_out_n), .dackEn(dackEn), .updateStrobe(updateStrobe),
        .activeCh(activeCh), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: bus requested / bus owned, cycle index t within a transfer
    // (1 = address, 2 = read strobe, >=3 = both strobes), last = update cycle.
    bit m_busy, m_owned, m_casc, m_last, m_pend, m_term;
    int m_t, m_ch, m_mode, m_type;
    int g_idx;

    task automatic model_idle();
        m_busy = 0; m_owned = 0; m_casc = 0; m_last = 0;
        m_pend = 0; m_term = 0; m_t = 0;
    endtask

    task automatic model_step();
        bit cont;
        if (RESET) begin
            model_idle();
            m_ch = 0;
        end else if (!m_busy) begin
            if (validDREQ && !ctrlDisable) begin
                m_busy = 1;
                m_ch   = g_idx;
                m_mode = int'(xferMode);
                m_type = int'(xferType);
                m_casc = (m_mode == 3);
            end
        end else if (!m_owned) begin
            if (!validDREQ || !EOP_in_n) model_idle();
            else if (HLDA) begin
                m_owned = 1;
                m_t = 1;
            end
        end else if (m_casc) begin
            if (!HLDA || !dreqLive[m_ch]) model_idle();
        end else if (m_last) begin
            cont = (m_mode == 2 && !m_term) ||
                   (m_mode == 0 && !m_term && dreqLive[m_ch]);
            if (cont) begin
                m_last = 0;
                m_t = 1;
            end else model_idle();
        end else if (!HLDA) begin
            model_idle();
        end else begin
            if (!EOP_in_n) m_pend = 1;
            if (m_t < 3) m_t++;
            else if (READY) begin
                m_last = 1;
                m_term = tc || m_pend;
            end else m_t++;
        end
    endtask

    task automatic compare_outputs();
        bit xfer, rd, wr;
        logic [9:0] exp_ctl;
        logic [NUM_CH-1:0] exp_dack;
        xfer = m_owned && !m_casc && !m_last;
        rd   = xfer && (m_t >= 2);
        wr   = xfer && (m_t >= 3);
        exp_ctl = {m_busy, m_owned && !m_casc, xfer && (m_t == 1),
                   !(m_type == 2 && rd), !(m_type == 1 && wr),
                   !(m_type == 1 && rd), !(m_type == 2 && wr),
                   !(m_last && m_term), m_last, m_busy};
        exp_dack = m_owned ? NUM_CH'(1 << m_ch) : '0;
        chk("ctl", 16'({HRQ, AEN, ADSTB, MEMR_n, MEMW_n, IOR_n, IOW_n,
                        EOP_out_n, updateStrobe, busy}), 16'(exp_ctl));
        chk("dack", 16'(dackEn), 16'(exp_dack));
        chk("activeCh", 16'(activeCh), 16'(m_ch));
    endtask

    int hcnt = 0;
    int hdly = 0;

    task automatic drive_random();
        RESET       = ($urandom_range(0, 299) == 0);
        validDREQ   = ($urandom_range(0, 99) < 92);
        g_idx       = $urandom_range(0, NUM_CH - 1);
        grant       = NUM_CH'(1 << g_idx);
        for (int i = 0; i < NUM_CH; i++) dreqLive[i] = ($urandom_range(0, 99) < 88);
        xferMode    = 2'($urandom_range(0, 3));
        xferType    = 2'($urandom_range(0, 3));
        ctrlDisable = ($urandom_range(0, 99) < 8);
        READY       = ($urandom_range(0, 99) < 70);
        EOP_in_n    = ($urandom_range(0, 99) >= 4);
        tc          = ($urandom_range(0, 99) < 20);
        if (!m_busy) begin
            hcnt = 0;
            hdly = $urandom_range(0, 3);
            HLDA = 1'b0;
        end else begin
            hcnt++;
            HLDA = (hcnt > hdly) && ($urandom_range(0, 49) != 0);
        end
    endtask

    initial begin
        model_idle();
        m_ch = 0; m_mode = 0; m_type = 0; g_idx = 0;
        RESET = 1'b1;
        repeat (2) begin
            @(posedge CLK);
            model_step();
        end
        @(negedge CLK);
        compare_outputs();
        RESET = 1'b0;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(posedge CLK);
            model_step();
            @(negedge CLK);
            compare_outputs();
            drive_random();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
